// File: rtl/wrr_grant_controller_pkg.sv
// Shared types and constants for the weighted round-robin grant controller.
// Holds the FSM state encoding, default sizes and a width helper.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N  = 4;
    localparam int DEF_WW = 3;
    localparam int DEF_HW = 8;

    // Index width that never collapses to zero bits, so N=2 still gets a 1-bit id.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrr_grant_controller_if.sv
// Requester-side bundle of the grant controller: requests, releases, configuration,
// the registered grant outputs and a state view for checkers.
interface wrr_grant_controller_if
    import arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int WW = DEF_WW,
    parameter int HW = DEF_HW
);
    localparam int IW = clog2_safe(N);

    // Handshake: req[i] is a level that the agent holds until it is served. grant[i]
    // acknowledges it one clock after arbitration and stays high until the owner
    // pulses done[i] for one cycle, drops req[i], or the hold limit expires.
    // done on a non-granted bit has no effect.
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N*WW-1:0] weight;
    logic [HW-1:0]   max_hold;

    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            timeout_pulse;
    arb_state_e      state;

    modport master (
        output req, done, weight, max_hold,
        input  grant, grant_id, busy, timeout_pulse, state
    );

    modport slave (
        input  req, done, weight, max_hold,
        output grant, grant_id, busy, timeout_pulse, state
    );

endinterface

// File: rtl/wrr_grant_controller_rr_pick.sv
// Rotating-priority picker: returns the first set bit of eligible searching from
// ptr+1 upward modulo N. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = clog2_safe(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int w_j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = 0;
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(ptr) + k) % N;
            if (!found && eligible[w_j]) begin
                found = 1'b1;
                idx   = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/wrr_grant_controller.sv
// Weighted round-robin grant controller: one registered one-hot grant, per-requester
// credits reloaded from weights when exhausted, and an optional hold limit.
module wrr_grant_controller
    import arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int WW = DEF_WW,
    parameter int HW = DEF_HW
) (
    input  logic                    clk,
    input  logic                    rstn,
    wrr_grant_controller_if.slave   bus
);

    localparam int           IW      = clog2_safe(N);
    localparam logic [N-1:0] ONE_HOT = N'(1);

    arb_state_e      r_state, w_state_nxt;
    logic [N-1:0]    r_grant, w_grant_nxt;
    logic [IW-1:0]   r_grant_id, w_grant_id_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [WW-1:0]   r_credit [N];
    logic [WW-1:0]   w_credit_nxt [N];
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic            r_timeout, w_timeout_nxt;

    logic [N-1:0]    w_eligible;
    logic            w_found_e, w_found_r;
    logic [IW-1:0]   w_idx_e, w_idx_r;
    logic            w_none_elig;
    logic            w_pick_found;
    logic [IW-1:0]   w_pick_idx;
    logic            w_owner_done, w_owner_req, w_hold_hit, w_exit;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_eligible[i] = bus.req[i] && (r_credit[i] != '0);
        end
    end

    rr_pick #(.N(N), .IW(IW)) u_pick_credit (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .found    (w_found_e),
        .idx      (w_idx_e)
    );

    // Fallback picker over all requesters, used in the cycle credits are reloaded.
    rr_pick #(.N(N), .IW(IW)) u_pick_reload (
        .eligible (bus.req),
        .ptr      (r_ptr),
        .found    (w_found_r),
        .idx      (w_idx_r)
    );

    assign w_none_elig  = !w_found_e;
    assign w_pick_found = w_none_elig ? w_found_r : w_found_e;
    assign w_pick_idx   = w_none_elig ? w_idx_r   : w_idx_e;

    assign w_owner_done = bus.done[r_grant_id];
    assign w_owner_req  = bus.req[r_grant_id];
    assign w_hold_hit   = (bus.max_hold != '0) && (r_hold == (bus.max_hold - HW'(1)));
    assign w_exit       = w_owner_done || !w_owner_req || w_hold_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= IW'(N - 1);
            r_hold     <= '0;
            r_timeout  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold     <= w_hold_nxt;
            r_timeout  <= w_timeout_nxt;
            r_credit   <= w_credit_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_hold_nxt     = r_hold;
        w_timeout_nxt  = 1'b0;
        w_credit_nxt   = r_credit;

        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    // Weight 0 reloads as 1 so a requester can never starve itself.
                    if (w_none_elig) begin
                        for (int i = 0; i < N; i++) begin
                            w_credit_nxt[i] = (bus.weight[i*WW +: WW] == '0) ?
                                              WW'(1) : bus.weight[i*WW +: WW];
                        end
                    end
                    w_grant_nxt    = ONE_HOT << w_pick_idx;
                    w_grant_id_nxt = w_pick_idx;
                    w_hold_nxt     = '0;
                    w_state_nxt    = GRANT;
                end
            end

            GRANT: begin
                w_hold_nxt = r_hold + HW'(1);
                if (w_exit) begin
                    if (r_credit[r_grant_id] != '0) begin
                        w_credit_nxt[r_grant_id] = r_credit[r_grant_id] - WW'(1);
                    end
                    w_ptr_nxt   = r_grant_id;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                    // A normal release in the limit cycle wins over the timeout.
                    w_timeout_nxt = w_hold_hit && !w_owner_done && w_owner_req;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.grant         = r_grant;
    assign bus.grant_id      = r_grant_id;
    assign bus.busy          = (r_grant != '0);
    assign bus.timeout_pulse = r_timeout;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_wrr_grant_controller.sv
// Directed bench for wrr_grant_controller: expected grant sequences go into a queue
// as each scenario is set up and are popped as grants appear.
module tb_wrr_grant_controller;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int WW = 3;
    localparam int HW = 8;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    wrr_grant_controller_if #(.N(N), .WW(WW), .HW(HW)) bus ();

    wrr_grant_controller #(.N(N), .WW(WW), .HW(HW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        bus.weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (bus.busy === 1'b1) break;
            tick();
        end
        check({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic take(input string tag, output logic [N-1:0] e);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_grant"}, 32'(bus.grant), 32'(e));
        check({tag, "_grant_id"}, 32'(bus.grant_id), 32'(oh_idx(e)));
    endtask

    // Serve n grants; each owner releases with done after 'hold' cycles, and the
    // next grant must follow exactly one idle cycle later.
    task automatic serve(input string tag, input int n, input int hold);
        logic [N-1:0] e;
        for (int k = 0; k < n; k++) begin
            if (k == 0) wait_busy(tag);
            take($sformatf("%s%0d", tag, k), e);
            repeat (hold - 1) tick();
            bus.done = e;
            tick();
            bus.done = '0;
            check($sformatf("%s%0d_idle", tag, k), 32'(bus.busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e;
        int len;

        bus.max_hold = '0;
        set_weights(1, 1, 1, 1);

        // Reset state
        do_reset();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout_pulse), 32'd0);
        check("rst_state", 32'(bus.state), 32'(IDLE));

        // Plain round-robin, done two cycles into each grant
        bus.req = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        serve("rr", 5, 2);

        // Weighting 2:1 between requesters 0 and 1
        do_reset();
        set_weights(2, 1, 1, 1);
        bus.req = 4'b0011;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        serve("wt", 7, 1);

        // Hold limit of 5 with no done
        do_reset();
        set_weights(1, 1, 1, 1);
        bus.max_hold = HW'(5);
        bus.req      = 4'b0001;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        wait_busy("hold");
        take("hold_first", e);
        len = 0;
        while (bus.busy && len < 32) begin
            len++;
            tick();
        end
        check("hold_len", 32'(len), 32'd5);
        check("hold_timeout_hi", 32'(bus.timeout_pulse), 32'd1);
        check("hold_idle_grant", 32'(bus.grant), 32'd0);
        tick();
        check("hold_timeout_lo", 32'(bus.timeout_pulse), 32'd0);
        take("hold_regrant", e);

        // done[0] in the limit cycle, done[2] on a non-owner
        do_reset();
        bus.max_hold = HW'(5);
        bus.req      = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_busy("coll");
        take("coll", e);
        bus.done = 4'b0100;
        tick();
        bus.done = '0;
        check("coll_nonowner_done", 32'(bus.grant), 32'h1);
        tick();
        tick();
        tick();
        bus.done = 4'b0001;
        tick();
        bus.done = '0;
        check("coll_release", 32'(bus.busy), 32'd0);
        check("coll_no_timeout", 32'(bus.timeout_pulse), 32'd0);

        // Owner 1 drops its request mid-grant
        do_reset();
        bus.max_hold = '0;
        bus.req      = 4'b1111;
        exp_q.push_back(4'b0001);
        serve("drop_pre", 1, 1);
        exp_q.push_back(4'b0010);
        take("drop_owner1", e);
        tick();
        bus.req = 4'b1101;
        tick();
        check("drop_release", 32'(bus.busy), 32'd0);
        check("drop_no_timeout", 32'(bus.timeout_pulse), 32'd0);
        bus.req = 4'b1111;
        tick();
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        serve("drop_post", 3, 1);

        // Asynchronous reset in the middle of a grant to requester 2
        do_reset();
        bus.req = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        serve("mid", 2, 2);
        exp_q.push_back(4'b0100);
        take("mid_owner2", e);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_timeout", 32'(bus.timeout_pulse), 32'd0);
        check("mid_rst_state", 32'(bus.state), 32'(IDLE));
        tick();
        rstn = 1'b1;
        exp_q.push_back(4'b0001);
        serve("after_rst", 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wrr_grant_controller.md
# wrr_grant_controller

Weighted round-robin controller that shares one downstream resource (bus, memory port, shared datapath) among N requesters. A grant is held until the owner signals completion, drops its request, or exceeds a programmable hold limit. Per-requester credit counters enforce configurable bandwidth weights, and a rotating pointer keeps the arbitration fair within each weight epoch. It sits between requester agents and the resource mux, and drives that mux select directly.

## Interface
- N, 4, number of requesters (2..16)
- WW, 3, weight and credit counter width
- HW, 8, hold-limit counter width
- clk  input  1  single clock, rising edge
- rstn  input  1  asynchronous active-low reset
- req  input  N  request level per requester; held until served
- done  input  N  one-cycle release pulse from the current owner; ignored on non-granted bits
- weight  input  N*WW  per-requester weight, slice i = weight[i*WW +: WW]; 0 is treated as 1
- max_hold  input  HW  maximum grant length in cycles; 0 = unlimited
- grant  output  N  one-hot grant, registered
- grant_id  output  $clog2(N)  index of owner; valid while busy
- busy  output  1  grant != 0
- timeout_pulse  output  1  one-cycle flag when a grant was revoked by the hold limit

## Operation
- Reset values: grant=0, grant_id=0, busy=0, timeout_pulse=0, state=IDLE, ptr=N-1 (requester 0 gets first priority), all credits=0, hold counter=0.
- States: IDLE and GRANT.
- IDLE, no req: stay in IDLE.
- IDLE, any req: combinational pick.
  - Eligible: req[i]=1 and credit[i]!=0.
  - If none are eligible, reload every credit[i] from weight (0 maps to 1) and pick among all requesting agents in the same cycle.
  - Search order: ptr+1, ptr+2, … modulo N; first hit wins.
  - At the next edge: grant, grant_id and state=GRANT are registered, and the hold counter is cleared.
- GRANT (owner g):
  - The hold counter increments each cycle.
  - Exit when done[g]=1, or req[g]=0, or (max_hold!=0 and hold count = max_hold-1).
  - On exit: credit[g] decrements (saturates at 0), ptr<=g, grant<=0, state<=IDLE.
- Minimum one idle (grant=0) cycle between consecutive grants, including re-grant to the same requester. This provides bus turnaround.
- timeout_pulse is registered. It is high during the idle cycle following a hold-limit exit, and only then.
- Simultaneous done[g] and hold limit: treated as a normal release; no timeout_pulse.
- weight is sampled only at reload. max_hold is sampled every cycle, so lowering it mid-grant can end the grant immediately.
- Changes to req of non-owners during GRANT have no effect until the next IDLE arbitration.
- Reset asserted mid-grant: all outputs drop asynchronously to reset values. After release, arbitration restarts from requester 0.

## Timing
- Latency: req sampled high in IDLE at edge t → grant high after edge t (one clock).
- Release: done[g] sampled at edge t → grant low after edge t. The next grant appears after edge t+1 at the earliest.
- Grant length with hold limit: exactly max_hold cycles.
- Maximum throughput: one grant per (hold + 1) cycles.
- No combinational path from inputs to outputs.

## Structure
- Package arb_pkg:
  - typedef enum logic arb_state_e {IDLE, GRANT}
  - localparam constants for default N, WW and HW
  - function clog2_safe
- Sub-module rr_pick: purely combinational rotate-priority picker with inputs eligible[N] and ptr, outputs found and idx. It is instantiated twice, once for the credit-eligible set and once for the reload set, and the result is selected by "no eligible".
- The top level holds the FSM, credit array, pointer and hold counter. Target size 150–250 lines.

## Test plan
- Reset: drive rstn=0 during an active grant → grant=0, grant_id=0, busy=0 and timeout_pulse=0 immediately. After release with req=4'b1111, the first grant is 4'b0001.
- Plain round-robin: all weights 1, max_hold=0, req=4'b1111, each owner pulses done two cycles after grant → grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- Weighting: weight0=2, weight1=1, req=4'b0011 constant, done immediately → grant order 0,1,0,1,0,0,1.
- Hold limit: max_hold=5, req=4'b0001 held, no done → grant[0] high for exactly 5 cycles, then timeout_pulse high in the single idle cycle, then re-grant to 0.
- Collisions: done[0] coincides with the hold-limit cycle → release with no timeout_pulse. done[2] pulsed while 0 owns the grant → ignored, grant unchanged.
- Request drop: owner 1 deasserts req[1] mid-grant without done → grant drops the next cycle, credit[1] decrements, and the next arbitration starts at requester 2.
